// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: round-robin arbiter for two command ports.
// It loads the granted command into the ALU with three writes (op, A, B),
// waits for the ALU result, and returns it tagged with the requester id.
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | arbitrate, accept one command
// WR_OP   | write opcode to ALU address 0
// WR_A    | write operand A to ALU address 1
// WR_B    | write operand B to ALU address 2
// WAIT    | count down the ALU result latency, then capture
// RESP    | hold response until consumer takes it
module alu_cmd_sequencer #(
  parameter int OPERAND_WIDTH    = 8,
  parameter int INST_ADDR_LENGTH = 2,
  parameter int RESULT_LATENCY   = 1
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        req0Valid,
  output logic                        req0Ready,
  input  logic [OPERAND_WIDTH-1:0]    req0Op,
  input  logic [OPERAND_WIDTH-1:0]    req0A,
  input  logic [OPERAND_WIDTH-1:0]    req0B,
  input  logic                        req1Valid,
  output logic                        req1Ready,
  input  logic [OPERAND_WIDTH-1:0]    req1Op,
  input  logic [OPERAND_WIDTH-1:0]    req1A,
  input  logic [OPERAND_WIDTH-1:0]    req1B,
  output logic                        rspValid,
  input  logic                        rspReady,
  output logic                        rspId,
  output logic [OPERAND_WIDTH-1:0]    rspData,
  output logic [3:0]                  rspFlags,
  output logic                        aluWriteEn,
  output logic [INST_ADDR_LENGTH-1:0] aluWriteAddress,
  output logic [OPERAND_WIDTH-1:0]    aluInst,
  input  logic [OPERAND_WIDTH-1:0]    aluResult,
  input  logic                        aluError,
  input  logic                        aluOverflow,
  input  logic                        aluCarry,
  input  logic                        aluZero,
  output logic [7:0]                  errCount,
  output logic                        busy
);

  localparam int CNT_W = $clog2(RESULT_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_OP, S_WR_A, S_WR_B, S_WAIT, S_RESP
  } state_t;

  state_t                     state, state_next;
  logic                       rr_ptr;
  logic                       grant;
  logic                       accept;
  logic [CNT_W-1:0]           lat_cnt;
  logic [OPERAND_WIDTH-1:0]   hold_op, hold_a, hold_b;
  logic                       cnt_done;

  assign cnt_done = (lat_cnt == CNT_W'(1));

  // Grant: a lone requester wins outright, a tie goes to rr_ptr.
  always_comb begin
    grant = rr_ptr;
    if (req0Valid && !req1Valid)      grant = 1'b0;
    else if (req1Valid && !req0Valid) grant = 1'b1;
  end

  assign accept = (req0Valid && req0Ready) || (req1Valid && req1Ready);

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_WR_OP;
      S_WR_OP: state_next = S_WR_A;
      S_WR_A:  state_next = S_WR_B;
      S_WR_B:  state_next = S_WAIT;
      S_WAIT:  if (cnt_done) state_next = S_RESP;
      S_RESP:  if (rspReady) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; ALU write port is idle-zero outside WR_*.
  always_comb begin
    req0Ready       = (state == S_IDLE) && (grant == 1'b0);
    req1Ready       = (state == S_IDLE) && (grant == 1'b1);
    rspValid        = (state == S_RESP);
    busy            = (state != S_IDLE);
    aluWriteEn      = 1'b0;
    aluWriteAddress = '0;
    aluInst         = '0;
    case (state)
      S_WR_OP: begin
        aluWriteEn      = 1'b1;
        aluWriteAddress = INST_ADDR_LENGTH'(0);
        aluInst         = hold_op;
      end
      S_WR_A: begin
        aluWriteEn      = 1'b1;
        aluWriteAddress = INST_ADDR_LENGTH'(1);
        aluInst         = hold_a;
      end
      S_WR_B: begin
        aluWriteEn      = 1'b1;
        aluWriteAddress = INST_ADDR_LENGTH'(2);
        aluInst         = hold_b;
      end
      default: ;
    endcase
  end

  // Command holding, round-robin pointer, latency counter, response capture.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rr_ptr   <= 1'b0;
      hold_op  <= '0;
      hold_a   <= '0;
      hold_b   <= '0;
      rspId    <= 1'b0;
      lat_cnt  <= '0;
      rspData  <= '0;
      rspFlags <= '0;
      errCount <= '0;
    end else begin
      if (state == S_IDLE && accept) begin
        hold_op <= grant ? req1Op : req0Op;
        hold_a  <= grant ? req1A  : req0A;
        hold_b  <= grant ? req1B  : req0B;
        rspId   <= grant;
        rr_ptr  <= ~grant;
      end
      if (state == S_WR_B)
        lat_cnt <= CNT_W'(RESULT_LATENCY);
      else if (state == S_WAIT)
        lat_cnt <= lat_cnt - CNT_W'(1);
      if (state == S_WAIT && cnt_done) begin
        rspData  <= aluResult;
        rspFlags <= {aluError, aluOverflow, aluCarry, aluZero};
      end
      if (rspValid && rspReady && rspFlags[3] && errCount != 8'hFF)
        errCount <= errCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU.
module tb_alu_cmd_sequencer;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_DIV = 8'h05;
  localparam logic [7:0] OP_BAD = 8'hEE;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic req0Valid = 0, req1Valid = 0;
  logic req0Ready, req1Ready;
  logic [7:0] req0Op = 0, req0A = 0, req0B = 0;
  logic [7:0] req1Op = 0, req1A = 0, req1B = 0;
  logic rspValid, rspReady = 1'b1, rspId;
  logic [7:0] rspData;
  logic [3:0] rspFlags;
  logic aluWriteEn;
  logic [1:0] aluWriteAddress;
  logic [7:0] aluInst, aluResult;
  logic aluError, aluOverflow, aluCarry, aluZero;
  logic [7:0] errCount;
  logic busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.OPERAND_WIDTH(8), .INST_ADDR_LENGTH(2), .RESULT_LATENCY(1)) dut (
    .clk(clk), .rstN(rstN),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Op(req0Op), .req0A(req0A), .req0B(req0B),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Op(req1Op), .req1A(req1A), .req1B(req1B),
    .rspValid(rspValid), .rspReady(rspReady), .rspId(rspId), .rspData(rspData), .rspFlags(rspFlags),
    .aluWriteEn(aluWriteEn), .aluWriteAddress(aluWriteAddress), .aluInst(aluInst),
    .aluResult(aluResult), .aluError(aluError), .aluOverflow(aluOverflow),
    .aluCarry(aluCarry), .aluZero(aluZero), .errCount(errCount), .busy(busy)
  );

  // Behavioural ALU: register file written by the DUT, combinational result.
  logic [7:0] m_op = 0, m_a = 0, m_b = 0;
  always @(posedge clk) begin
    if (aluWriteEn) begin
      case (aluWriteAddress)
        2'd0: m_op <= aluInst;
        2'd1: m_a  <= aluInst;
        2'd2: m_b  <= aluInst;
        default: ;
      endcase
    end
  end

  logic [8:0] sum9;
  always_comb begin
    sum9        = {1'b0, m_a} + {1'b0, m_b};
    aluResult   = 8'h00;
    aluError    = 1'b0;
    aluOverflow = 1'b0;
    aluCarry    = 1'b0;
    case (m_op)
      OP_ADD: begin
        aluResult   = sum9[7:0];
        aluCarry    = sum9[8];
        aluOverflow = (m_a[7] == m_b[7]) && (sum9[7] != m_a[7]);
      end
      OP_DIV: begin
        if (m_b == 8'h00) aluError = 1'b1;
        else              aluResult = m_a / m_b;
      end
      default: aluError = 1'b1;
    endcase
    aluZero = !aluError && (aluResult == 8'h00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstN = 1'b0;
    #2;
    rstN = 1'b1;
  endtask

  // Issue one command and check the write sequence and the response.
  // Returns in RESP if rspReady is low, otherwise after the handshake edge.
  task automatic run_cmd(input int port, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_d, input logic [3:0] exp_f);
    bit got = 0;
    @(negedge clk);
    if (port == 0) begin req0Valid = 1; req0Op = op; req0A = a; req0B = b; end
    else           begin req1Valid = 1; req1Op = op; req1A = a; req1B = b; end
    for (int n = 0; n < 50 && !got; n++) begin
      if ((port == 0 && req0Ready) || (port == 1 && req1Ready)) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      check("grant_timeout", 32'd0, 32'd1);
      req0Valid = 0; req1Valid = 0;
      return;
    end
    @(posedge clk); #1;
    req0Valid = 0; req1Valid = 0;
    @(negedge clk);
    check("wr_op", {aluWriteEn, aluWriteAddress, aluInst}, {1'b1, 2'd0, op});
    @(negedge clk);
    check("wr_a", {aluWriteEn, aluWriteAddress, aluInst}, {1'b1, 2'd1, a});
    @(negedge clk);
    check("wr_b", {aluWriteEn, aluWriteAddress, aluInst}, {1'b1, 2'd2, b});
    @(negedge clk);
    check("wait_quiet", {rspValid, aluWriteEn, busy}, {1'b0, 1'b0, 1'b1});
    @(negedge clk);
    check("rsp_valid", rspValid, 1'b1);
    check("rsp_data", rspData, exp_d);
    check("rsp_flags", rspFlags, exp_f);
    check("rsp_id", rspId, port[0]);
    if (rspReady) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    int         port;
    logic [7:0] op, a, b;
    logic [7:0] exp_d;
    logic [3:0] exp_f;
  } vec_t;

  vec_t vecs[6];
  int   grants[4];
  int   g;
  int   bad;
  logic [7:0] err_before;

  initial begin
    vecs[0] = '{0, OP_ADD, 8'h05, 8'h03, 8'h08, 4'b0000};
    vecs[1] = '{1, OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011};
    vecs[2] = '{0, OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0100};
    vecs[3] = '{1, OP_DIV, 8'h10, 8'h02, 8'h08, 4'b0000};
    vecs[4] = '{0, OP_DIV, 8'h10, 8'h00, 8'h00, 4'b1000};
    vecs[5] = '{1, OP_BAD, 8'h01, 8'h01, 8'h00, 4'b1000};

    // Reset values
    #12;
    check("rst_alu", {aluWriteEn, aluWriteAddress, aluInst}, 11'd0);
    check("rst_rsp", {rspValid, rspId, rspData, rspFlags}, 14'd0);
    check("rst_misc", {errCount, busy}, 9'd0);
    check("rst_ready", {req0Ready, req1Ready}, 2'b10);
    @(negedge clk);
    rstN = 1'b1;

    // Table-driven single commands
    for (int i = 0; i < 6; i++)
      run_cmd(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_f);
    @(negedge clk);
    check("err_after_table", errCount, 8'd2);

    // Round-robin with both ports valid continuously
    do_reset();
    @(negedge clk);
    req0Valid = 1; req0Op = OP_ADD; req0A = 1; req0B = 1;
    req1Valid = 1; req1Op = OP_ADD; req1A = 1; req1B = 1;
    g = 0;
    for (int n = 0; n < 200 && g < 4; n++) begin
      if (req0Valid && req0Ready)      begin grants[g] = 0; g++; end
      else if (req1Valid && req1Ready) begin grants[g] = 1; g++; end
      if (g < 4) @(negedge clk);
    end
    req0Valid = 0; req1Valid = 0;
    check("rr_count", g, 4);
    check("rr_seq", {grants[0][0], grants[1][0], grants[2][0], grants[3][0]}, 4'b0101);

    // Only port1 valid: granted back to back
    @(negedge clk);
    req1Valid = 1;
    g = 0;
    for (int n = 0; n < 200 && g < 2; n++) begin
      if (req1Valid && req1Ready) begin grants[g] = 1; g++; end
      else if (req0Ready && req0Valid) begin grants[g] = 0; g++; end
      if (g < 2) @(negedge clk);
    end
    req1Valid = 0;
    check("p1_only_count", g, 2);
    check("p1_only_seq", {grants[0][0], grants[1][0]}, 2'b11);

    // Error counter increments and saturates
    do_reset();
    run_cmd(0, OP_DIV, 8'h10, 8'h00, 8'h00, 4'b1000);
    @(negedge clk);
    check("err_one", errCount, 8'd1);
    for (int i = 1; i < 260; i++)
      run_cmd(i % 2, OP_DIV, 8'h10, 8'h00, 8'h00, 4'b1000);
    @(negedge clk);
    check("err_sat", errCount, 8'd255);

    // Response backpressure: everything frozen while rspReady is low
    rspReady = 0;
    run_cmd(0, OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0100);
    req0Valid = 1; req0Op = OP_ADD; req0A = 8'h11; req0B = 8'h22;
    req1Valid = 1;
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (!(rspValid && rspData == 8'h80 && rspId == 1'b0 && rspFlags == 4'b0100
            && !req0Ready && !req1Ready && !aluWriteEn)) bad++;
    end
    check("stall_stable", bad, 0);
    rspReady = 1;
    @(posedge clk); #1;
    check("stall_idle_ready", {rspValid, busy, req0Ready || req1Ready}, 3'b001);
    check("stall_err_hold", errCount, 8'd255);
    req0Valid = 0; req1Valid = 0;

    // Reset during WR_A discards the command
    @(negedge clk);
    req0Valid = 1; req0Op = OP_ADD; req0A = 8'h09; req0B = 8'h09;
    @(posedge clk); #1;
    req0Valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_wr_a", {aluWriteEn, aluWriteAddress, aluInst}, {1'b1, 2'd1, 8'h09});
    rstN = 0;
    #1;
    check("rst_mid_we", aluWriteEn, 1'b0);
    check("rst_mid_busy_err", {busy, errCount}, 9'd0);
    @(posedge clk); #1;
    rstN = 1;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rspValid || busy || aluWriteEn) bad++;
    end
    check("no_rsp_after_rst", bad, 0);
    run_cmd(0, OP_ADD, 8'h02, 8'h02, 8'h04, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
